sync_mem_rw: RTL and testbench

- Parametrised single-clock memory with independent write and read channels; the read channel is pipelined and handshaked.
- Write channel takes per-byte strobes. Reads return through a valid/ready response port with configurable latency and backpressure.
- Reports out-of-range accesses as errors.
- Used as the instruction/data backing store in the core test environment and SoC top.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_rd_pipe.sv | 45 ++++
 rtl/sync_mem_rw.sv | 100 ++++++++++
 tb/tb_sync_mem_rw.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous read/write memory.
// Latency bounds, collision encodings and the address decoder.
package mem_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam int COLLIDE_OLD = 0;
  localparam int COLLIDE_NEW = 1;

  localparam int IDX_W = 32;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Byte address to word index; the low two bits are dropped.
  function automatic dec_t addr_decode(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] depth
  );
    dec_t        d;
    logic [63:0] off;
    off   = addr - base;
    d.ok  = (addr >= base) && ((off >> 2) < depth);
    d.idx = off[IDX_W+1:2];
    return d;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// LAT-stage valid/data/err shift pipeline with one global stall.
// Ports: clock, reset, advance, in_* (stage 1 load), out_* (last stage).
module mem_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  logic [LAT-1:0] v;
  logic [LAT-1:0] e;
  logic [W-1:0]   d [LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < LAT; i++) begin
        d[i] <= '0;
      end
    end else if (advance) begin
      v[0] <= in_valid;
      d[0] <= in_data;
      e[0] <= in_err;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
        e[i] <= e[i-1];
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];
  assign out_err   = e[LAT-1];

endmodule

// File: rtl/sync_mem_rw.sv
// Single-clock memory: byte-strobed write port, pipelined read port.
// Ports: clock/reset, w_* write channel, r_* read request, rsp_* response.
module sync_mem_rw
  import mem_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 1024,
  parameter int              AW           = $clog2(DEPTH),
  parameter int              RD_LAT       = 1,
  parameter int              COLLIDE_MODE = COLLIDE_OLD,
  parameter logic [XLEN-1:0] BASE_ADDR    = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [XLEN-1:0]   w_addr,
  input  logic [XLEN/8-1:0] w_strb,
  input  logic [XLEN-1:0]   w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [XLEN-1:0]   r_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err
);

  localparam int NB = XLEN / 8;

  // Out-of-range latency settings are pulled back into the legal window.
  localparam int LAT =
    (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
    (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [XLEN-1:0] mem [DEPTH];

  dec_t            w_dec;
  dec_t            r_dec;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   r_idx;
  logic            w_hit;
  logic            collide;
  logic            advance;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] rd_load;
  logic            unused_idx;

  assign w_dec = addr_decode(64'(w_addr), 64'(BASE_ADDR), 64'(DEPTH));
  assign r_dec = addr_decode(64'(r_addr), 64'(BASE_ADDR), 64'(DEPTH));
  assign w_idx = w_dec.idx[AW-1:0];
  assign r_idx = r_dec.idx[AW-1:0];

  assign unused_idx = ^{w_dec.idx[IDX_W-1:AW], r_dec.idx[IDX_W-1:AW]};

  assign w_ready = 1'b1;
  assign w_hit   = w_valid & w_dec.ok & ~reset;
  assign advance = ~rsp_valid | rsp_ready;
  assign r_ready = advance;

  // Write-first bypass for a same-word read in the same cycle.
  assign collide = (COLLIDE_MODE == COLLIDE_NEW) && w_hit &&
                   r_dec.ok && (w_idx == r_idx);

  always_ff @(posedge clock) begin
    if (w_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (w_strb[i]) begin
          mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[r_idx];
    for (int i = 0; i < NB; i++) begin
      if (collide && w_strb[i]) begin
        rd_word[8*i +: 8] = w_data[8*i +: 8];
      end
    end
    rd_load = r_dec.ok ? rd_word : '0;
  end

  mem_rd_pipe #(
    .W   (XLEN),
    .LAT (LAT)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .advance   (advance),
    .in_valid  (r_valid),
    .in_data   (rd_load),
    .in_err    (~r_dec.ok),
    .out_valid (rsp_valid),
    .out_data  (rsp_data),
    .out_err   (rsp_err)
  );

endmodule

// File: tb/tb_sync_mem_rw.sv
// Bench for sync_mem_rw: two configurations driven by shared stimulus,
// each checked every cycle against a queue-based reference model.
module tb_sync_mem_rw;

  localparam int          DEPTH = 1024;
  localparam int          LAT0  = 3;
  localparam int          LAT1  = 2;
  localparam logic [31:0] BASE0 = 32'h0;
  localparam logic [31:0] BASE1 = 32'h1000;
  localparam int          MODE0 = 0;
  localparam int          MODE1 = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        w_valid;
  logic [31:0] w_addr;
  logic [3:0]  w_strb;
  logic [31:0] w_data;
  logic        r_valid;
  logic [31:0] r_addr;
  logic        rsp_ready;

  logic [1:0]       wrdy;
  logic [1:0]       rr;
  logic [1:0]       rv;
  logic [1:0]       re;
  logic [1:0][31:0] rd;

  always #5 clock = ~clock;

  sync_mem_rw #(
    .XLEN(32), .DEPTH(DEPTH), .RD_LAT(LAT0),
    .COLLIDE_MODE(MODE0), .BASE_ADDR(BASE0)
  ) dut_a (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(wrdy[0]), .w_addr(w_addr),
    .w_strb(w_strb), .w_data(w_data),
    .r_valid(r_valid), .r_ready(rr[0]), .r_addr(r_addr),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
    .rsp_data(rd[0]), .rsp_err(re[0])
  );

  sync_mem_rw #(
    .XLEN(32), .DEPTH(DEPTH), .RD_LAT(LAT1),
    .COLLIDE_MODE(MODE1), .BASE_ADDR(BASE1)
  ) dut_b (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(wrdy[1]), .w_addr(w_addr),
    .w_strb(w_strb), .w_data(w_data),
    .r_valid(r_valid), .r_ready(rr[1]), .r_addr(r_addr),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
    .rsp_data(rd[1]), .rsp_err(re[1])
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          rem;
  } ent_t;

  logic [31:0] mm [2][DEPTH];
  ent_t        fq [2][8];
  int          hd [2] = '{0, 0};
  int          cnt [2] = '{0, 0};
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_d [2];
  logic        last_e [2];
  int          npop [2] = '{0, 0};
  bit          chk_on = 1'b0;

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] base_of(int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int mode_of(int k);
    return (k == 0) ? MODE0 : MODE1;
  endfunction

  function automatic bit in_rng(int k, logic [31:0] a);
    return (a >= base_of(k)) && (((a - base_of(k)) >> 2) < 32'(DEPTH));
  endfunction

  function automatic int idx_of(int k, logic [31:0] a);
    return int'((a - base_of(k)) >> 2);
  endfunction

  function automatic logic [31:0] initv(int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 50)
        $display("FAIL %s dut%0d: got %h want %h at %0t",
                 nm, k, got, exp, $time);
    end
  endtask

  // Reference: in-order queue; each entry counts the advancing edges
  // still needed before it reaches the response port.
  task automatic model_step(int k);
    bit          ev;
    bit          adv;
    ent_t        n;
    logic [31:0] w;
    ev  = (cnt[k] > 0) && (fq[k][hd[k]].rem == 0);
    adv = !ev || rsp_ready;
    if (reset) begin
      cnt[k] = 0;
      hd[k]  = 0;
      return;
    end
    if (adv) begin
      if (ev) begin
        hd[k]  = (hd[k] + 1) % 8;
        cnt[k] = cnt[k] - 1;
      end
      for (int j = 0; j < cnt[k]; j++)
        fq[k][(hd[k] + j) % 8].rem = fq[k][(hd[k] + j) % 8].rem - 1;
      if (r_valid) begin
        n.rem = lat_of(k) - 1;
        if (!in_rng(k, r_addr)) begin
          n.d = '0;
          n.e = 1'b1;
        end else begin
          w = mm[k][idx_of(k, r_addr)];
          if (mode_of(k) == 1 && w_valid && in_rng(k, w_addr) &&
              idx_of(k, w_addr) == idx_of(k, r_addr))
            for (int i = 0; i < 4; i++)
              if (w_strb[i]) w[8*i +: 8] = w_data[8*i +: 8];
          n.d = w;
          n.e = 1'b0;
        end
        fq[k][(hd[k] + cnt[k]) % 8] = n;
        cnt[k] = cnt[k] + 1;
      end
    end
    if (w_valid && in_rng(k, w_addr))
      for (int i = 0; i < 4; i++)
        if (w_strb[i])
          mm[k][idx_of(k, w_addr)][8*i +: 8] = w_data[8*i +: 8];
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset && rv[k] && rsp_ready) begin
        last_d[k] = rd[k];
        last_e[k] = re[k];
        npop[k]   = npop[k] + 1;
      end
      model_step(k);
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        bit ev;
        ev = (cnt[k] > 0) && (fq[k][hd[k]].rem == 0);
        chk("rsp_valid", k, 32'(rv[k]), 32'(ev));
        chk("r_ready", k, 32'(rr[k]), 32'(!ev || rsp_ready));
        chk("w_ready", k, 32'(wrdy[k]), 32'd1);
        if (ev) begin
          chk("rsp_data", k, rd[k], fq[k][hd[k]].d);
          chk("rsp_err", k, 32'(re[k]), 32'(fq[k][hd[k]].e));
        end
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle();
    w_valid = 1'b0;
    w_strb  = '0;
    r_valid = 1'b0;
  endtask

  task automatic wr(logic [31:0] a, logic [3:0] s, logic [31:0] d);
    w_valid = 1'b1;
    w_addr  = a;
    w_strb  = s;
    w_data  = d;
    cyc();
    idle();
  endtask

  task automatic rdq(logic [31:0] a);
    r_valid = 1'b1;
    r_addr  = a;
    cyc();
    r_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    rsp_ready = 1'b1;
    cyc(10);
  endtask

  int sa [6];
  int sb [6];
  int ea [6] = '{0, 0, 1, 1, 1, 0};
  int eb [6] = '{0, 1, 1, 1, 0, 0};
  int p0 [2];

  initial begin
    idle();
    w_addr    = '0;
    w_data    = '0;
    r_addr    = '0;
    rsp_ready = 1'b1;
    cyc(2);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", k, 32'(rv[k]), 32'd0);
      chk("reset_data", k, rd[k], 32'd0);
      chk("reset_err", k, 32'(re[k]), 32'd0);
    end
    chk_on = 1'b1;
    reset  = 1'b0;

    for (int i = 0; i < 2 * DEPTH; i++)
      wr(32'(i * 4), 4'hF, initv(i));

    wr(32'h10, 4'hF, 32'hAABB_CCDD);
    wr(32'h10, 4'h2, 32'h0000_1100);
    rdq(32'h10);
    drain();
    chk("lane_a_data", 0, last_d[0], 32'hAABB_11DD);
    chk("lane_a_err", 0, 32'(last_e[0]), 32'd0);
    chk("oor_b_data", 1, last_d[1], 32'd0);
    chk("oor_b_err", 1, 32'(last_e[1]), 32'd1);
    wr(32'h1010, 4'hF, 32'hAABB_CCDD);
    wr(32'h1010, 4'h2, 32'h0000_1100);
    rdq(32'h1010);
    drain();
    chk("lane_b_data", 1, last_d[1], 32'hAABB_11DD);
    chk("oor_a_err", 0, 32'(last_e[0]), 32'd1);

    for (int j = 0; j < 6; j++) begin
      r_valid = (j < 3);
      r_addr  = 32'(4 * j);
      @(posedge clock);
      @(negedge clock);
      sa[j] = int'(rv[0]);
      sb[j] = int'(rv[1]);
    end
    r_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("lat3_valid", 0, 32'(sa[j]), 32'(ea[j]));
      chk("lat2_valid", 1, 32'(sb[j]), 32'(eb[j]));
    end
    drain();

    rsp_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      r_valid = 1'b1;
      r_addr  = 32'h100 + 32'(4 * j);
      cyc();
    end
    r_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        chk("stall_r_ready", k, 32'(rr[k]), 32'd0);
        chk("stall_valid", k, 32'(rv[k]), 32'd1);
      end
    end
    p0[0] = npop[0];
    p0[1] = npop[1];
    drain();
    chk("bp_count", 0, 32'(npop[0] - p0[0]), 32'd3);
    chk("bp_count", 1, 32'(npop[1] - p0[1]), 32'd2);

    wr(32'h20, 4'hF, 32'h1234_5678);
    wr(32'h1020, 4'hF, 32'h1234_5678);
    w_valid = 1'b1; w_addr = 32'h20; w_strb = 4'h1; w_data = '1;
    rdq(32'h20);
    drain();
    chk("collide_old", 0, last_d[0], 32'h1234_5678);
    w_valid = 1'b1; w_addr = 32'h1020; w_strb = 4'h1; w_data = '1;
    rdq(32'h1020);
    drain();
    chk("collide_new", 1, last_d[1], 32'h1234_56FF);

    rsp_ready = 1'b0;
    rdq(32'h20);
    rdq(32'h1020);
    reset   = 1'b1;
    w_valid = 1'b1; w_addr = 32'h20; w_strb = 4'hF; w_data = 32'hDEAD_BEEF;
    cyc();
    reset = 1'b0;
    idle();
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      chk("post_reset_valid", 0, 32'(rv[0]), 32'd0);
      chk("post_reset_valid", 1, 32'(rv[1]), 32'd0);
    end
    cyc();
    rdq(32'h20);
    drain();
    chk("keep_mem", 0, last_d[0], 32'h1234_56FF);
    rdq(32'h1020);
    drain();
    chk("keep_mem", 1, last_d[1], 32'h1234_56FF);

    rdq(32'h0FFC);
    drain();
    chk("below_base_err", 1, 32'(last_e[1]), 32'd1);
    chk("below_base_data", 1, last_d[1], 32'd0);
    chk("top_word_err", 0, 32'(last_e[0]), 32'd0);
    rdq(32'h2000);
    drain();
    chk("above_top_err", 0, 32'(last_e[0]), 32'd1);
    chk("above_top_err", 1, 32'(last_e[1]), 32'd1);
    chk("above_top_data", 1, last_d[1], 32'd0);
    wr(32'h2000, 4'hF, 32'hFFFF_FFFF);

    for (int c = 0; c < 3000; c++) begin
      w_valid   = 1'($urandom_range(0, 1));
      w_addr    = 32'($urandom_range(0, 32'h23FF));
      w_strb    = 4'($urandom_range(0, 15));
      w_data    = $urandom;
      r_valid   = 1'($urandom_range(0, 1));
      r_addr    = ($urandom_range(0, 3) == 0) ? w_addr :
                  32'($urandom_range(0, 32'h23FF));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    for (int i = 0; i < 2 * DEPTH; i++)
      rdq(32'(i * 4));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
